// File: rtl/edf_dispatcher_if.sv
// rtl/edf_dispatcher_if.sv - task intake and dispatch signal bundle for edf_dispatcher
interface edf_dispatcher_if #(
  parameter int ID_W   = 8,
  parameter int TIME_W = 16,
  parameter int CORE   = 16
);
  localparam int TASK_W = 1 + ID_W + 2 * TIME_W;
  localparam int CIDX_W = $clog2(CORE);

  logic              in_valid;
  logic              in_ready;
  logic [TASK_W-1:0] in_task;
  logic              dispatch_valid;
  logic [CIDX_W-1:0] dispatch_core;
  logic [TASK_W-1:0] dispatch_task;
  logic              preempt_valid;

  modport master (
    output in_valid, in_task,
    input  in_ready, dispatch_valid, dispatch_core, dispatch_task, preempt_valid
  );

  modport slave (
    input  in_valid, in_task,
    output in_ready, dispatch_valid, dispatch_core, dispatch_task, preempt_valid
  );
endinterface

// File: rtl/edf_dispatcher.sv
// rtl/edf_dispatcher.sv - deadline-sorted ready queue dispatching to cores with preemption
module edf_dispatcher #(
  parameter int ID_W   = 8,
  parameter int TIME_W = 16,
  parameter int CORE   = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                tick,
  input  logic [CORE-1:0]                     core_busy,
  input  logic [CORE*(1+ID_W+2*TIME_W)-1:0]   core_task,
  edf_dispatcher_if.slave                     bus,
  output logic                                drop_valid,
  output logic [(1+ID_W+2*TIME_W)-1:0]        drop_task,
  output logic [$clog2(DEPTH+1)-1:0]          q_count,
  output logic [CNT_W-1:0]                    dispatch_cnt,
  output logic [CNT_W-1:0]                    preempt_cnt,
  output logic [CNT_W-1:0]                    drop_cnt
);
  localparam int TASK_W = 1 + ID_W + 2 * TIME_W;
  localparam int CIDX_W = $clog2(CORE);
  localparam int QC_W   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, REINSERT} state_t;
  typedef logic [TASK_W-1:0] task_t;

  state_t            state;
  task_t             q [DEPTH];
  task_t             evicted;
  logic [CIDX_W-1:0] scan_idx;

  function automatic logic [TIME_W-1:0] key_of(input logic crit, input logic [TIME_W-1:0] dl,
                                               input logic [TIME_W-1:0] ex);
    return crit ? dl - ex : dl;
  endfunction

  function automatic task_t tick_dec(input task_t t);
    task_t r;
    r = t;
    if (t[2*TIME_W-1:TIME_W] != '0)
      r[2*TIME_W-1:TIME_W] = t[2*TIME_W-1:TIME_W] - TIME_W'(1);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  logic              all_busy, decide, preempt, pop, in_ready_i, write, ins, drop_hit;
  logic [CIDX_W-1:0] idle_core;
  logic [TIME_W-1:0] ins_key;
  task_t             scan_task, ins_task;
  task_t             qx [DEPTH+1];
  task_t             bx [DEPTH+1];
  task_t             merged [DEPTH+1];
  int                base_cnt, merged_cnt, pos;

  always_comb begin
    all_busy  = &core_busy;
    idle_core = '0;
    for (int c = CORE - 1; c >= 0; c--)
      if (!core_busy[c]) idle_core = CIDX_W'(c);
    scan_task = core_task[int'(scan_idx)*TASK_W +: TASK_W];

    decide  = (state == SCAN) && enable && (q_count != '0);
    preempt = decide && all_busy &&
              (key_of(q[0][TASK_W-1], q[0][2*TIME_W-1:TIME_W], q[0][TIME_W-1:0]) <
               key_of(scan_task[TASK_W-1], scan_task[2*TIME_W-1:TIME_W], scan_task[TIME_W-1:0]));
    pop     = decide && (!all_busy || preempt);

    // A pop in the same cycle frees the slot a new task needs
    in_ready_i = (state != REINSERT) && ((int'(q_count) < DEPTH) || pop);
    write      = bus.in_valid && in_ready_i;
    ins        = (state == REINSERT) || write;
    ins_task   = (state == REINSERT) ? evicted : bus.in_task;
    ins_key    = key_of(ins_task[TASK_W-1], ins_task[2*TIME_W-1:TIME_W], ins_task[TIME_W-1:0]);

    base_cnt = int'(q_count) - (pop ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) qx[i] = q[i];
    qx[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bx[i] = pop ? qx[i+1] : qx[i];
      if (tick) bx[i] = tick_dec(bx[i]);
      if (i >= base_cnt) bx[i] = '0;
    end
    bx[DEPTH] = '0;

    // New task goes behind every entry whose key does not exceed its own
    pos = base_cnt;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (i < base_cnt &&
          key_of(bx[i][TASK_W-1], bx[i][2*TIME_W-1:TIME_W], bx[i][TIME_W-1:0]) > ins_key)
        pos = i;

    merged[0] = (!ins || pos > 0) ? bx[0] : ins_task;
    for (int i = 1; i <= DEPTH; i++) begin
      if (!ins || i < pos)  merged[i] = bx[i];
      else if (i == pos)    merged[i] = ins_task;
      else                  merged[i] = bx[i-1];
    end
    merged_cnt = base_cnt + (ins ? 1 : 0);
    drop_hit   = merged_cnt > DEPTH;
  end

  assign bus.in_ready       = in_ready_i;
  assign bus.dispatch_valid = pop;
  assign bus.dispatch_core  = !pop ? '0 : (preempt ? scan_idx : idle_core);
  assign bus.dispatch_task  = pop ? q[0] : '0;
  assign bus.preempt_valid  = preempt;
  assign drop_valid         = drop_hit;
  assign drop_task          = drop_hit ? merged[DEPTH] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      evicted      <= '0;
      scan_idx     <= '0;
      q_count      <= '0;
      dispatch_cnt <= '0;
      preempt_cnt  <= '0;
      drop_cnt     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= merged[i];
      q_count <= drop_hit ? QC_W'(DEPTH) : QC_W'(merged_cnt);
      if (preempt) begin
        evicted <= scan_task;
        state   <= REINSERT;
      end else if (merged_cnt == 0) begin
        state <= IDLE;
      end else begin
        state <= SCAN;
      end
      if (decide && all_busy && !preempt)
        scan_idx <= (int'(scan_idx) == CORE - 1) ? '0 : scan_idx + CIDX_W'(1);
      dispatch_cnt <= sat_inc(dispatch_cnt, pop);
      preempt_cnt  <= sat_inc(preempt_cnt, preempt);
      drop_cnt     <= sat_inc(drop_cnt, drop_hit);
    end
  end
endmodule
